// File: rtl/seq_arb_4in_rotating_if.sv
// Request/grant bundle between four requesters and the rotating arbiter.
// The master drives requests; the arbiter (slave) returns a one-hot grant.
interface seq_arb_4in_rotating_if;
    logic [3:0] reqs;
    logic [3:0] grants;

    modport master (output reqs, input grants);
    modport slave  (input reqs, output grants);
endinterface

// File: rtl/seq_arb_4in_rotating.sv
// Four-way round-robin arbiter: zero-latency grant from a registered one-hot
// priority pointer, which rotates so the last winner becomes lowest priority.
module seq_arb_4in_rotating (
    input  logic                   clk,
    input  logic                   reset,
    seq_arb_4in_rotating_if.slave  arb
);
    logic [3:0] prio;
    logic [7:0] req_dbl;
    logic [7:0] gnt_dbl;
    logic [3:0] grants_c;

    // Subtracting the pointer from the doubled request vector clears every
    // request below it; the lowest surviving set bit is the winner, and the
    // upper copy of the requests supplies the wrap-around.
    always_comb begin
        req_dbl  = {arb.reqs, arb.reqs};
        gnt_dbl  = req_dbl & ~(req_dbl - {4'b0000, prio});
        grants_c = gnt_dbl[3:0] | gnt_dbl[7:4];
    end

    assign arb.grants = grants_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= 4'b0001;
        end else if (grants_c != 4'b0000) begin
            prio <= {grants_c[2:0], grants_c[3]};
        end
    end
endmodule

// File: tb/tb_seq_arb_4in_rotating.sv
// Scoreboard bench for the rotating arbiter: the stimulus pushes expected
// grants into a queue, and a negedge monitor pops and compares them.
module tb_seq_arb_4in_rotating;
    logic clk;
    logic reset;

    seq_arb_4in_rotating_if arb_if ();

    seq_arb_4in_rotating dut (
        .clk   (clk),
        .reset (reset),
        .arb   (arb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] exp_q[$];
    logic [3:0] model_prio;
    int checks   = 0;
    int failures = 0;

    // Independent reference: linear scan from the pointer index upward.
    function automatic logic [3:0] model_grant(input logic [3:0] p, input logic [3:0] r);
        int start;
        logic [3:0] g;
        start = 0;
        g = 4'b0000;
        for (int i = 0; i < 4; i++) if (p[i]) start = i;
        for (int k = 0; k < 4; k++) begin
            if (g == 4'b0000 && r[(start + k) % 4]) g[(start + k) % 4] = 1'b1;
        end
        return g;
    endfunction

    // Applies one cycle of inputs; hand-computed expectation unless use_model.
    task automatic step(input logic rs, input logic [3:0] rq, input logic [3:0] exp_g,
                        input bit use_model);
        logic [3:0] g;
        @(posedge clk);
        #1;
        reset = rs;
        arb_if.reqs = rq;
        g = model_grant(model_prio, rq);
        exp_q.push_back(use_model ? g : exp_g);
        if (rs) model_prio = 4'b0001;
        else if (g != 4'b0000) model_prio = {g[2:0], g[3]};
    endtask

    initial begin
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (arb_if.grants !== e) begin
                    failures++;
                    $display("FAIL grants: got %b expected %b (reqs=%b reset=%b) t=%0t",
                             arb_if.grants, e, arb_if.reqs, reset, $time);
                end
                checks++;
                if ($countones(arb_if.grants) > 1) begin
                    failures++;
                    $display("FAIL onehot: got %b expected at most one bit set t=%0t",
                             arb_if.grants, $time);
                end
            end
        end
    end

    initial begin
        logic [3:0] all_rr[10];
        int budget;
        reset = 1'b1;
        arb_if.reqs = 4'b0000;
        model_prio = 4'b0001;

        // Reset, then one requester at a time.
        step(1, 4'b0000, 4'b0000, 0);
        step(1, 4'b0000, 4'b0000, 0);
        step(0, 4'b0000, 4'b0000, 0);
        step(0, 4'b0001, 4'b0001, 0);
        step(0, 4'b0010, 4'b0010, 0);
        step(0, 4'b0100, 4'b0100, 0);
        step(0, 4'b1000, 4'b1000, 0);
        step(0, 4'b0000, 4'b0000, 0);
        step(0, 4'b0001, 4'b0001, 0);

        // All requesting for 10 cycles after reset.
        all_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
                   4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        step(1, 4'b0000, 4'b0000, 0);
        step(1, 4'b0000, 4'b0000, 0);
        for (int i = 0; i < 10; i++) step(0, 4'b1111, all_rr[i], 0);

        // Reset mid-stream: first reset cycle still uses the old pointer.
        step(1, 4'b0000, 4'b0000, 0);
        step(1, 4'b0000, 4'b0000, 0);
        step(0, 4'b1111, 4'b0001, 0);
        step(0, 4'b1111, 4'b0010, 0);
        step(0, 4'b1111, 4'b0100, 0);
        step(1, 4'b1111, 4'b1000, 0);
        step(1, 4'b1111, 4'b0001, 0);
        step(1, 4'b1111, 4'b0001, 0);
        step(0, 4'b1111, 4'b0001, 0);
        step(0, 4'b1111, 4'b0010, 0);
        step(0, 4'b1111, 4'b0100, 0);
        step(0, 4'b1111, 4'b1000, 0);

        // Skip non-requesters, with wrap from index 3 back to 0.
        step(1, 4'b0000, 4'b0000, 0);
        step(0, 4'b0001, 4'b0001, 0);
        step(0, 4'b1001, 4'b1000, 0);
        step(0, 4'b1001, 4'b0001, 0);

        // Idle cycles hold the pointer.
        step(1, 4'b0000, 4'b0000, 0);
        step(0, 4'b0010, 4'b0010, 0);
        step(0, 4'b0000, 4'b0000, 0);
        step(0, 4'b0000, 4'b0000, 0);
        step(0, 4'b0011, 4'b0001, 0);

        // Random requests, then random requests with random reset.
        for (int i = 0; i < 20; i++) step(0, 4'($urandom_range(0, 15)), 4'b0000, 1);
        for (int i = 0; i < 20; i++)
            step(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 4'b0000, 1);

        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
